// File: rtl/multi_toggle_sync_rx.sv
// Destination-side receiver for toggle-encoded pulse crossings, one lane per bit.
// Each lane synchronises its toggle, emits a pulse per edge and queues events in a saturating counter.
module multi_toggle_sync_rx #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       toggle_in,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       ev_valid,
  input  logic [CHANNELS-1:0]       ev_ready,
  output logic [CHANNELS*CNT_W-1:0] ev_count,
  output logic [CHANNELS-1:0]       overflow,
  input  logic [CHANNELS-1:0]       clr_ovf
);

  localparam int                   GUARD_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [GUARD_W-1:0]   GUARD_INIT = GUARD_W'(SYNC_STAGES + 1);
  localparam logic [GUARD_W-1:0]   GUARD_ONE  = {{(GUARD_W-1){1'b0}}, 1'b1};
  localparam logic [GUARD_W-1:0]   GUARD_ZERO = {GUARD_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_r;
  logic [CHANNELS-1:0]                  hist_r;
  logic [GUARD_W-1:0]                   guard_r;
  logic [CNT_W-1:0]                     cnt_r [CHANNELS];
  logic                                 masked_s;
  logic [CHANNELS-1:0]                  edge_s;
  logic [CHANNELS-1:0]                  inc_s;
  logic [CHANNELS-1:0]                  dec_s;
  logic [CHANNELS-1:0]                  set_ovf_s;

  assign masked_s = (guard_r != GUARD_ZERO);
  assign edge_s   = sync_r[SYNC_STAGES-1] ^ hist_r;

  // Synchroniser chain, edge history, post-reset guard window and registered pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r    <= {(SYNC_STAGES*CHANNELS){1'b0}};
      hist_r    <= {CHANNELS{1'b0}};
      guard_r   <= GUARD_INIT;
      pulse_out <= {CHANNELS{1'b0}};
    end else begin
      sync_r[0] <= toggle_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
      hist_r <= sync_r[SYNC_STAGES-1];
      if (masked_s) begin
        guard_r <= guard_r - GUARD_ONE;
      end else begin
        guard_r <= guard_r;
      end
      // A lane tracking a high toggle at release would otherwise see a false edge.
      pulse_out <= edge_s & ~{CHANNELS{masked_s}};
    end
  end

  // Per-lane handshake decode and packed count view.
  always_comb begin
    ev_valid  = {CHANNELS{1'b0}};
    ev_count  = {(CHANNELS*CNT_W){1'b0}};
    inc_s     = pulse_out;
    dec_s     = {CHANNELS{1'b0}};
    set_ovf_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      ev_valid[i]                 = (cnt_r[i] != CNT_ZERO);
      ev_count[i*CNT_W +: CNT_W]  = cnt_r[i];
      dec_s[i]                    = ev_valid[i] & ev_ready[i];
      set_ovf_s[i]                = inc_s[i] & ~dec_s[i] & (cnt_r[i] == CNT_MAX);
    end
  end

  // Saturating pending-event counters and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      overflow <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10: begin
            if (cnt_r[i] != CNT_MAX) begin
              cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end else begin
              cnt_r[i] <= cnt_r[i];
            end
          end
          2'b01:   cnt_r[i] <= cnt_r[i] - CNT_ONE;
          default: cnt_r[i] <= cnt_r[i];
        endcase
        if (set_ovf_s[i]) begin
          overflow[i] <= 1'b1;
        end else if (clr_ovf[i]) begin
          overflow[i] <= 1'b0;
        end else begin
          overflow[i] <= overflow[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_toggle_sync_rx.sv
// Directed bench for multi_toggle_sync_rx: a sample-history model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_multi_toggle_sync_rx;

  localparam int CH  = 4;
  localparam int S   = 2;
  localparam int W   = 3;
  localparam int MAX = (1 << W) - 1;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] toggle_in;
  logic [CH-1:0] pulse_out;
  logic [CH-1:0] ev_valid;
  logic [CH-1:0] ev_ready;
  logic [CH*W-1:0] ev_count;
  logic [CH-1:0] overflow;
  logic [CH-1:0] clr_ovf;

  int checks;
  int errors;

  // model: toggle samples taken at past edges (index 0 = most recent)
  logic [CH-1:0] smp [0:S];
  logic [CH-1:0] m_pulse;
  logic [CH-1:0] m_ovf;
  int            m_cnt [CH];
  int            since_rst;
  bit            model_live;

  multi_toggle_sync_rx #(.CHANNELS(CH), .SYNC_STAGES(S), .CNT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .toggle_in (toggle_in),
    .pulse_out (pulse_out),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_count  (ev_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: a lane's pulse is the change between the samples taken S and S+1
  // edges ago, suppressed for the first S+1 edges after reset; counters follow the handshake rules.
  task automatic model_edge();
    logic [CH-1:0] newp;
    if (!rst_n) begin
      for (int j = 0; j <= S; j++) smp[j] = '0;
      m_pulse    = '0;
      m_ovf      = '0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
      since_rst  = 0;
      model_live = 1'b1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit inc, dec, setf;
        inc  = m_pulse[i];
        dec  = (m_cnt[i] != 0) && ev_ready[i];
        setf = inc && !dec && (m_cnt[i] == MAX);
        if (inc && !dec && m_cnt[i] < MAX) m_cnt[i] = m_cnt[i] + 1;
        if (dec && !inc) m_cnt[i] = m_cnt[i] - 1;
        if (setf) m_ovf[i] = 1'b1;
        else if (clr_ovf[i]) m_ovf[i] = 1'b0;
      end
      since_rst++;
      newp = (smp[S-1] ^ smp[S]);
      if (since_rst < S + 2) newp = '0;
      for (int j = S; j > 0; j--) smp[j] = smp[j-1];
      smp[0]  = toggle_in;
      m_pulse = newp;
    end
  endtask

  task automatic compare();
    logic [CH*W-1:0] vc;
    logic [CH-1:0]   vv;
    if (model_live) begin
      for (int i = 0; i < CH; i++) begin
        vc[i*W +: W] = W'(m_cnt[i]);
        vv[i]        = (m_cnt[i] != 0);
      end
      check("model_pulse_out", 32'(pulse_out), 32'(m_pulse));
      check("model_ev_valid",  32'(ev_valid),  32'(vv));
      check("model_ev_count",  32'(ev_count),  32'(vc));
      check("model_overflow",  32'(overflow),  32'(m_ovf));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_live = 1'b0;
    since_rst  = 0;
    rst_n      = 1'b0;
    toggle_in  = 4'b0101;
    ev_ready   = 4'b0000;
    clr_ovf    = 4'b0000;

    // 1: reset with toggles high, no spurious pulse after release
    step(); step();
    rst_n = 1'b1;
    repeat (S + 1 + 5) begin
      step();
      check("t1_no_pulse", 32'(pulse_out), 32'h0);
      check("t1_count_zero", 32'(ev_count), 32'h0);
    end

    // 2: single lane0 rise, pulse after edge k+2, count 1
    rst_n = 1'b0; toggle_in = 4'b0000; step();
    rst_n = 1'b1; repeat (5) step();
    toggle_in = 4'b0001;
    step(); step();
    check("t2_pulse_early", 32'(pulse_out), 32'h0);
    step();
    check("t2_pulse", 32'(pulse_out), 32'h1);
    step();
    check("t2_pulse_once", 32'(pulse_out), 32'h0);
    check("t2_count", 32'(ev_count), 32'h001);
    check("t2_valid", 32'(ev_valid), 32'h1);

    // 3: lane1 saturation and overflow clear
    for (int n = 0; n < 8; n++) begin
      toggle_in[1] = ~toggle_in[1];
      step(); step();
    end
    repeat (4) step();
    check("t3_sat_count", 32'(ev_count[5:3]), 32'd7);
    check("t3_overflow", 32'(overflow), 32'h2);
    clr_ovf = 4'b0010; step(); clr_ovf = 4'b0000;
    check("t3_ovf_clear", 32'(overflow), 32'h0);

    // 4: inc and dec together at max
    toggle_in[1] = ~toggle_in[1];
    step(); step(); step();
    check("t4_pulse", 32'(pulse_out), 32'h2);
    ev_ready = 4'b0010; step(); ev_ready = 4'b0000;
    check("t4_count_max", 32'(ev_count), 32'h039);
    check("t4_no_ovf", 32'(overflow), 32'h0);

    // 5: all lanes toggle together with lanes 1 and 3 ready
    ev_ready = 4'b1111; repeat (10) step();
    check("t5_drained", 32'(ev_count), 32'h0);
    ev_ready  = 4'b1010;
    toggle_in = ~toggle_in;
    step(); step(); step();
    check("t5_pulse_all", 32'(pulse_out), 32'hF);
    step();
    check("t5_inc_all", 32'(ev_count), 32'h249);
    step();
    check("t5_drain_odd", 32'(ev_count), 32'h041);
    check("t5_valid", 32'(ev_valid), 32'h5);
    step();
    check("t5_hold", 32'(ev_count), 32'h041);

    // 6: counts {3,0,5,1}, then one-cycle reset with a pulse in flight
    ev_ready = 4'b0000;
    toggle_in = toggle_in ^ 4'b1101; step(); step();
    toggle_in = toggle_in ^ 4'b0101; step(); step();
    toggle_in = toggle_in ^ 4'b0100; step(); step();
    toggle_in = toggle_in ^ 4'b0100; step(); step();
    repeat (4) step();
    check("t6_counts", 32'(ev_count), 32'h343);
    toggle_in[3] = ~toggle_in[3];
    step(); step();
    rst_n = 1'b0; step();
    check("t6_rst_count", 32'(ev_count), 32'h0);
    check("t6_rst_ovf", 32'(overflow), 32'h0);
    check("t6_rst_pulse", 32'(pulse_out), 32'h0);
    check("t6_rst_valid", 32'(ev_valid), 32'h0);
    rst_n = 1'b1;
    toggle_in[1] = ~toggle_in[1];
    repeat (6) step();
    check("t6_guard_lost", 32'(ev_count), 32'h0);
    toggle_in[2] = ~toggle_in[2];
    repeat (4) step();
    check("t6_rearmed", 32'(ev_count), 32'h040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
